// File: rtl/f_stage_if.sv
// F->D bundle for the fetch stage: decode control inputs, the instruction
// memory request/response pair and the decoded fetch fields.
// FETCH_ADEL_EN adds the f_adel misaligned-fetch flag to the bundle.
interface f_stage_if;
  logic        D_stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [5:0]  f_op;
  logic [5:0]  f_func;
  logic [4:0]  f_rs;
  logic [4:0]  f_rt;
  logic [4:0]  f_rd;
  logic [31:0] f_valC;
  logic [31:0] f_pc;
  logic        f_valid;
`ifdef FETCH_ADEL_EN
  logic        f_adel;
`endif

  // Fetch stage side
  modport master (
`ifdef FETCH_ADEL_EN
    output f_adel,
`endif
    input  D_stall, redirect, redirect_pc, imem_rdata,
    output imem_addr, f_op, f_func, f_rs, f_rt, f_rd, f_valC, f_pc, f_valid
  );

  // Decode / memory side
  modport slave (
`ifdef FETCH_ADEL_EN
    input  f_adel,
`endif
    output D_stall, redirect, redirect_pc, imem_rdata,
    input  imem_addr, f_op, f_func, f_rs, f_rt, f_rd, f_valC, f_pc, f_valid
  );
endinterface

// File: rtl/f_stage.sv
// Fetch stage: holds the PC, drives a synchronous instruction memory, splits
// the returned word into fields and builds valC. A one-word hold buffer lets
// decode stall without losing or duplicating words; redirects restart fetch.
// Optional feature macro: FETCH_ADEL_EN (flags the first word after a
// redirect whose target had nonzero low address bits).
module f_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic     clk,
  input  logic     rst_n,
  f_stage_if.master bus
);

  localparam logic [1:0] BOOT = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_ANDI = 6'h0c;
  localparam logic [5:0] OP_ORI  = 6'h0d;
  localparam logic [5:0] OP_XORI = 6'h0e;
  localparam logic [5:0] OP_LUI  = 6'h0f;

  logic [1:0]  state;
  logic [1:0]  next_state;
  logic [31:0] pc_q;
  logic [31:0] cur_pc;
  logic [31:0] hold_q;
  logic [31:0] hold_pc;
  logic [31:0] fetch_addr;
  logic        advance;
  logic        capture;
  logic        presenting;
  logic [31:0] pres_word;
  logic [31:0] pres_pc;
  logic [3:0]  jump_region;
  logic [27:0] pc_plus4_unused;
  logic [15:0] imm;
  logic [31:0] valc;

  // Address sent to memory: a redirect target wins over the sequential PC
  always_comb begin
    fetch_addr = pc_q;
    if (bus.redirect) begin
      fetch_addr = {bus.redirect_pc[31:2], 2'b00};
    end
  end

  assign bus.imem_addr = fetch_addr;

  // Decide whether to issue a new fetch, capture the live word, and where to go next
  always_comb begin
    advance    = 1'b0;
    capture    = 1'b0;
    next_state = state;
    if (bus.redirect) begin
      advance    = 1'b1;
      next_state = RUN;
    end else begin
      case (state)
        RUN: begin
          if (bus.D_stall) begin
            capture    = 1'b1;
            next_state = HOLD;
          end else begin
            advance = 1'b1;
          end
        end
        HOLD: begin
          if (!bus.D_stall) begin
            advance    = 1'b1;
            next_state = RUN;
          end
        end
        default: begin
          advance    = 1'b1;
          next_state = RUN;
        end
      endcase
    end
  end

  // PC, in-flight address, hold buffer and state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= BOOT;
      pc_q    <= RESET_PC;
      cur_pc  <= 32'h0;
      hold_q  <= 32'h0;
      hold_pc <= 32'h0;
    end else begin
      state <= next_state;
      if (advance) begin
        pc_q   <= fetch_addr + 32'd4;
        cur_pc <= fetch_addr;
      end
      if (capture) begin
        hold_q  <= bus.imem_rdata;
        hold_pc <= cur_pc;
      end else if (bus.redirect) begin
        hold_q  <= 32'h0;
        hold_pc <= 32'h0;
      end
    end
  end

  // Pick the held or live word as a whole; bubbles force everything to zero
  always_comb begin
    presenting = !bus.redirect && ((state == RUN) || (state == HOLD));
    pres_word  = 32'h0;
    pres_pc    = 32'h0;
    if (presenting) begin
      pres_word = (state == HOLD) ? hold_q  : bus.imem_rdata;
      pres_pc   = (state == HOLD) ? hold_pc : cur_pc;
    end
  end

  assign {jump_region, pc_plus4_unused} = pres_pc + 32'd4;
  assign imm = pres_word[15:0];

  // Extended constant: logical immediates zero-extend, LUI shifts, jumps build a region address
  always_comb begin
    case (pres_word[31:26])
      OP_ANDI, OP_ORI, OP_XORI: valc = {16'h0, imm};
      OP_LUI:                   valc = {imm, 16'h0};
      OP_J, OP_JAL:             valc = {jump_region, pres_word[25:0], 2'b00};
      default:                  valc = {{16{imm[15]}}, imm};
    endcase
  end

  assign bus.f_op    = pres_word[31:26];
  assign bus.f_rs    = pres_word[25:21];
  assign bus.f_rt    = pres_word[20:16];
  assign bus.f_rd    = pres_word[15:11];
  assign bus.f_func  = pres_word[5:0];
  assign bus.f_valC  = valc;
  assign bus.f_pc    = pres_pc;
  assign bus.f_valid = presenting;

`ifdef FETCH_ADEL_EN
  logic cur_adel;
  logic hold_adel;

  // Misaligned-target flag follows its word through the live and held paths
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_adel  <= 1'b0;
      hold_adel <= 1'b0;
    end else begin
      if (advance) begin
        cur_adel <= bus.redirect && (bus.redirect_pc[1:0] != 2'b00);
      end
      if (capture) begin
        hold_adel <= cur_adel;
      end else if (bus.redirect) begin
        hold_adel <= 1'b0;
      end
    end
  end

  assign bus.f_adel = presenting && ((state == HOLD) ? hold_adel : cur_adel);
`else
  logic low_bits_unused;
  assign low_bits_unused = ^bus.redirect_pc[1:0];
`endif

endmodule
